// File: rtl/frequency_meter_pkg.sv
// Shared display-panel definitions for the frequency meter.
// Holds the measurement state encoding, the panel clock rate and the
// default gate length derived from it.
package frequency_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_GATE = 2'd2
    } fm_state_e;

    localparam int CLK_HZ              = 50_000_000;
    localparam int GATE_SECONDS        = 1;
    localparam int GATE_CYCLES_DEFAULT = CLK_HZ * GATE_SECONDS;
    localparam int CNT_W_DEFAULT       = 26;

endpackage

// File: rtl/frequency_meter_edge_sync.sv
// edge_sync: two-flop synchronizer for an asynchronous input followed by a
// history flop, producing a one-cycle pulse on each synchronized rising edge.
// Shared with the panel's button inputs.
//   clk  in   system clock
//   rst  in   synchronous active-high reset (clears all three flops)
//   din  in   asynchronous input
//   rise out  synchronized level high while previous level low
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    // sh[0], sh[1]: synchronizer; sh[2]: previous synchronized level
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/frequency_meter.sv
// frequency_meter: counts synchronized rising edges of sig_in over a gate
// window of GATE_CYCLES clk cycles and publishes the count at window end.
// Windows run back to back while run is high.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   run        in   level enable; low returns to idle next cycle
//   sig_in     in   asynchronous signal under measurement
//   freq_count out  edge count of the last completed window
//   valid      out  one-cycle pulse when freq_count updates
//   overflow   out  last completed window saturated the counter
//   busy       out  registered, high in SYNC and GATE
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | counters held at 0, results hold last values
// ST_SYNC | two cycles flushing the synchronizer, edges ignored
// ST_GATE | counting edges, window restarts back to back
module frequency_meter
    import frequency_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    fm_state_e         state_q;
    fm_state_e         state_d;
    logic              sync_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_cnt_nx;
    logic              sat;
    logic              sat_nx;
    logic              sig_rise;
    logic              window_end;

    edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (sig_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sync_cnt <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_cnt <= (state_q == ST_SYNC) ? ~sync_cnt : 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (run) state_d = ST_SYNC;
            ST_SYNC: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (sync_cnt) begin
                    state_d = ST_GATE;
                end
            end
            ST_GATE: if (!run) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign window_end = (state_q == ST_GATE) && (gate_cnt == GATE_LAST);

    // Saturation flag is raised by an edge arriving while the counter is
    // already at full scale, so a window of exactly CNT_MAX edges is exact.
    always_comb begin
        edge_cnt_nx = edge_cnt;
        sat_nx      = sat;
        if (sig_rise) begin
            if (edge_cnt == CNT_MAX) begin
                sat_nx = 1'b1;
            end else begin
                edge_cnt_nx = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_count <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy  <= (state_d != ST_IDLE);
            valid <= 1'b0;
            // A window ending as run drops is still published.
            if (window_end) begin
                freq_count <= edge_cnt_nx;
                overflow   <= sat_nx;
                valid      <= 1'b1;
            end
            // Restart in the publish cycle itself so no edge falls between windows.
            if ((state_d != ST_GATE) || window_end) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (state_q == ST_GATE) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_cnt_nx;
                sat      <= sat_nx;
            end
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
module tb_frequency_meter;

    localparam int G    = 100;
    localparam int W    = 4;
    localparam int MAXC = 15;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         run    = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] freq_count;
    logic         valid;
    logic         overflow;
    logic         busy;

    frequency_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sig_in     (sig_in),
        .freq_count (freq_count),
        .valid      (valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int fc;
        int ovf;
        int cyc;
    } rec_t;
    rec_t vals[$];

    // Reference model: counts sampled rises of sig_in between run start and
    // each window boundary using plain arithmetic on the cycle offset.
    bit       m_active = 0;
    int       k        = 0;
    int       total    = 0;
    int       m_fc     = 0;
    bit       m_valid  = 0;
    bit       m_ovf    = 0;
    bit       m_busy   = 0;
    logic [3:0] h      = '0;
    int       m_start  = 0;

    always @(posedge clk) begin
        bit rise;
        cyc++;
        if (rst) begin
            m_active = 0; k = 0; total = 0; m_fc = 0;
            m_valid = 0; m_ovf = 0; m_busy = 0; h = '0;
        end else begin
            rise = h[1] & ~h[2];
            h = {h[2:0], sig_in};
            m_valid = 0;
            if (m_active) begin
                k++;
                if (k >= 3) begin
                    total += int'(rise);
                    if ((k - 2) % G == 0) begin
                        m_valid = 1;
                        m_ovf   = (total > MAXC);
                        m_fc    = m_ovf ? MAXC : total;
                        total   = 0;
                    end
                end
                if (!run) m_active = 0;
            end else if (run) begin
                m_active = 1; k = 0; total = 0; m_start = cyc;
            end
            m_busy = m_active;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        chk("valid", int'(valid), int'(m_valid));
        chk("freq_count", int'(freq_count), m_fc);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'(m_busy));
        if (valid === 1'b1) vals.push_back('{int'(freq_count), int'(overflow), cyc});
    end

    // Stimulus generator: 0 manual, 1 periodic, 2 random hold lengths
    int mode      = 0;
    int period    = 2;
    int phase     = 0;
    int hold_left = 0;
    int hold_max  = 4;

    task automatic tick();
        @(negedge clk);
        case (mode)
            1: begin
                phase  = (phase + 1) % period;
                sig_in = (phase < period / 2);
            end
            2: begin
                if (hold_left == 0) begin
                    sig_in    = ~sig_in;
                    hold_left = $urandom_range(0, hold_max - 1);
                end else begin
                    hold_left--;
                end
            end
            default: ;
        endcase
    endtask

    task automatic set_period(int p);
        mode   = 1;
        period = p;
        phase  = p - 1;
    endtask

    task automatic wait_vals(int n, int budget, string name);
        for (int i = 0; i < budget && vals.size() < n; i++) tick();
        chk(name, vals.size(), n);
    endtask

    task automatic go_idle();
        run = 1'b0;
        repeat (5) tick();
        vals.delete();
    endtask

    initial begin
        // Reset and idle with a toggling input
        set_period(2);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_busy", int'(busy), 0);
            chk("idle_valid", int'(valid), 0);
            chk("idle_fc", int'(freq_count), 0);
            chk("idle_ovf", int'(overflow), 0);
        end
        chk("idle_nvalid", vals.size(), 0);

        // Steady count, period 10
        vals.delete();
        set_period(10);
        tick();
        run = 1'b1;
        wait_vals(4, 600, "steady_wait");
        if (vals.size() >= 4) begin
            chk("steady_first_cycle", vals[0].cyc - m_start + 1, 103);
            for (int i = 0; i < 4; i++) begin
                chk("steady_fc", vals[i].fc, 10);
                chk("steady_ovf", vals[i].ovf, 0);
                if (i > 0) chk("steady_spacing", vals[i].cyc - vals[i-1].cyc, 100);
            end
        end

        // Boundary: one rise in the first cycle of window 0, one in the last
        // cycle of window 1, nothing in window 2
        mode = 0;
        sig_in = 1'b0;
        go_idle();
        for (int j = 0; j < 3 * G + 6; j++) begin
            tick();
            run    = 1'b1;
            sig_in = ((j >= 1) && (j <= 50)) || ((j >= 2 * G) && (j <= 2 * G + 20));
        end
        chk("bnd_n", vals.size(), 3);
        if (vals.size() >= 3) begin
            chk("bnd_w0", vals[0].fc, 1);
            chk("bnd_w1", vals[1].fc, 1);
            chk("bnd_w2", vals[2].fc, 0);
        end

        // Saturation then recovery
        go_idle();
        set_period(4);
        tick();
        run = 1'b1;
        wait_vals(2, 400, "sat_wait");
        if (vals.size() >= 2) begin
            chk("sat_fc", vals[0].fc, 15);
            chk("sat_ovf", vals[0].ovf, 1);
        end
        set_period(20);
        wait_vals(4, 400, "slow_wait");
        if (vals.size() >= 4) begin
            chk("slow_fc", vals[3].fc, 5);
            chk("slow_ovf", vals[3].ovf, 0);
        end

        // Abort at gate_cnt = 50
        go_idle();
        tick();
        run = 1'b1;
        for (int j = 1; j <= 53; j++) begin
            tick();
            if (j == 53) run = 1'b0;
        end
        chk("abort_busy_before", int'(busy), 1);
        tick();
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_fc_kept", int'(freq_count), 5);
        repeat (60) tick();
        chk("abort_nvalid", vals.size(), 0);
        tick();
        run = 1'b1;
        wait_vals(1, 300, "rerun_wait");
        if (vals.size() >= 1) begin
            chk("rerun_first_cycle", vals[0].cyc - m_start + 1, 103);
            chk("rerun_fc", vals[0].fc, 5);
        end

        // Reset at gate_cnt = 99
        go_idle();
        tick();
        run = 1'b1;
        for (int j = 1; j <= 102; j++) begin
            tick();
            if (j == 102) rst = 1'b1;
        end
        tick();
        chk("rstmid_valid", int'(valid), 0);
        chk("rstmid_fc", int'(freq_count), 0);
        chk("rstmid_ovf", int'(overflow), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_nvalid", vals.size(), 0);
        rst = 1'b0;

        // Randomized segments against the model
        mode = 2;
        for (int seg = 0; seg < 12; seg++) begin
            hold_max = $urandom_range(1, 10);
            for (int i = 0; i < 500; i++) begin
                tick();
                rst = 1'b0;
                if ($urandom_range(0, 1999) == 0) rst = 1'b1;
                if (!run) begin
                    if ($urandom_range(0, 3) == 0) run = 1'b1;
                end else if ($urandom_range(0, 399) == 0) begin
                    run = 1'b0;
                end
            end
        end
        run = 1'b0;
        rst = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
